// File: rtl/tdm_demux_1to4_pkg.sv
// Shared definitions for the TDM 1:4 demux receive path: slot geometry and
// framing-state encodings.
package tdm_demux_1to4_pkg;

  localparam int unsigned TDM_SLOTS  = 4;
  localparam int unsigned TDM_SLOT_W = 2;

  localparam logic [TDM_SLOT_W-1:0] LAST_SLOT = TDM_SLOT_W'(TDM_SLOTS - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux_1to4_slot_counter.sv
// Slot index tracker: clear, load-to-1 on an accepted sync beat, or advance
// on an ordinary valid beat, wrapping naturally from the last slot back to 0.
module tdm_demux_1to4_slot_counter
  import tdm_demux_1to4_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load1,
  input  logic                  clr,
  output logic [TDM_SLOT_W-1:0] slot
);

  // Clear wins over load, load wins over advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= TDM_SLOT_W'(1);
    end else if (en) begin
      slot <= slot + TDM_SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_1to4.sv
// Receive end of the 4:1 TDM mux: locks onto frame_sync, collects four slot
// samples and publishes them as a complete frame with a one-cycle word_valid.
module tdm_demux_1to4
  import tdm_demux_1to4_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  frame_sync,
  output logic [WIDTH-1:0]      out0,
  output logic [WIDTH-1:0]      out1,
  output logic [WIDTH-1:0]      out2,
  output logic [WIDTH-1:0]      out3,
  output logic                  word_valid,
  output logic [TDM_SLOT_W-1:0] slot,
  output logic                  locked,
  output logic                  sync_err,
  output logic [ERR_CNT_W-1:0]  err_count
);

  tdm_state_e     state;
  logic [WIDTH-1:0] sh0, sh1, sh2;

  logic beat_locked;
  logic slot_zero;
  logic miss_sync;
  logic early_sync;
  logic frame_err;

  assign beat_locked = in_valid && (state == LOCKED);
  assign slot_zero   = (slot == '0);
  assign miss_sync   = beat_locked && !frame_sync && slot_zero;
  assign early_sync  = beat_locked && frame_sync && !slot_zero;
  assign frame_err   = miss_sync || early_sync;
  assign locked      = (state == LOCKED);

  // Any accepted sync beat (HUNT or LOCKED) restarts the frame at slot 1.
  tdm_demux_1to4_slot_counter u_slot_counter (
    .clock (clock),
    .reset (reset),
    .en    (beat_locked && !frame_sync && !slot_zero),
    .load1 (in_valid && frame_sync),
    .clr   (miss_sync),
    .slot  (slot)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      sh0        <= '0;
      sh1        <= '0;
      sh2        <= '0;
      out0       <= '0;
      out1       <= '0;
      out2       <= '0;
      out3       <= '0;
      word_valid <= 1'b0;
      sync_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      word_valid <= 1'b0;
      sync_err   <= frame_err;
      if (frame_err && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end

      if (in_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              sh0   <= in_data;
              state <= LOCKED;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              sh0 <= in_data;
            end else if (slot_zero) begin
              state <= HUNT;
            end else if (slot == LAST_SLOT) begin
              // Publish only on a completed frame so partial frames never leak.
              out0       <= sh0;
              out1       <= sh1;
              out2       <= sh2;
              out3       <= in_data;
              word_valid <= 1'b1;
            end else if (slot == TDM_SLOT_W'(1)) begin
              sh1 <= in_data;
            end else begin
              sh2 <= in_data;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed bench for tdm_demux_1to4: a table of per-beat vectors with
// hand-computed expectations, plus async-reset and saturation sequences.
module tb_tdm_demux_1to4;

  logic       clock = 1'b0;
  logic       reset;
  logic [0:0] in_data;
  logic       in_valid;
  logic       frame_sync;
  logic [0:0] out0, out1, out2, out3;
  logic       word_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tdm_demux_1to4 #(.WIDTH(1), .ERR_CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .frame_sync (frame_sync),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .word_valid (word_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err),
    .err_count  (err_count)
  );

  // outs packed as {out0,out1,out2,out3}
  typedef struct {
    logic       v;
    logic       fs;
    logic       d;
    logic [3:0] outs;
    logic       wv;
    logic [1:0] slot;
    logic       lk;
    logic       se;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] pack(input logic [3:0] o, input logic wv, input logic [1:0] s,
                                       input logic lk, input logic se, input logic [7:0] ec);
    return {o, wv, s, lk, se, ec};
  endfunction

  function automatic logic [16:0] actual();
    return pack({out0, out1, out2, out3}, word_valid, slot, locked, sync_err, err_count);
  endfunction

  task automatic add(input logic v, input logic fs, input logic d, input logic [3:0] o,
                     input logic wv, input logic [1:0] s, input logic lk, input logic se,
                     input logic [7:0] ec);
    vec_t t;
    t.v = v; t.fs = fs; t.d = d; t.outs = o; t.wv = wv;
    t.slot = s; t.lk = lk; t.se = se; t.ec = ec;
    vecs.push_back(t);
  endtask

  // Fields: {outs(4) wv slot(2) lk se ec(8)}
  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got outs=%b wv=%b slot=%0d lk=%b se=%b ec=%0d, want outs=%b wv=%b slot=%0d lk=%b se=%b ec=%0d",
               name, act[16:13], act[12], act[11:10], act[9], act[8], act[7:0],
               exp[16:13], exp[12], exp[11:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic beat(input logic v, input logic fs, input logic d);
    in_valid = v; frame_sync = fs; in_data = d;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; frame_sync = 1'b0; in_data = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; frame_sync = 1'b0; in_data = 1'b0;

    // frame {1,0,1,1}
    add(1,1,1, 4'b0000, 0, 2'd1, 1, 0, 8'd0);
    add(1,0,0, 4'b0000, 0, 2'd2, 1, 0, 8'd0);
    add(1,0,1, 4'b0000, 0, 2'd3, 1, 0, 8'd0);
    add(1,0,1, 4'b1011, 1, 2'd0, 1, 0, 8'd0);
    // back-to-back frame {0,1,0,0}
    add(1,1,0, 4'b1011, 0, 2'd1, 1, 0, 8'd0);
    add(1,0,1, 4'b1011, 0, 2'd2, 1, 0, 8'd0);
    add(1,0,0, 4'b1011, 0, 2'd3, 1, 0, 8'd0);
    add(1,0,0, 4'b0100, 1, 2'd0, 1, 0, 8'd0);
    // frame {1,1,0,1} with a 3-cycle valid gap after slot 1
    add(1,1,1, 4'b0100, 0, 2'd1, 1, 0, 8'd0);
    add(1,0,1, 4'b0100, 0, 2'd2, 1, 0, 8'd0);
    add(0,1,1, 4'b0100, 0, 2'd2, 1, 0, 8'd0);
    add(0,0,1, 4'b0100, 0, 2'd2, 1, 0, 8'd0);
    add(0,0,0, 4'b0100, 0, 2'd2, 1, 0, 8'd0);
    add(1,0,0, 4'b0100, 0, 2'd3, 1, 0, 8'd0);
    add(1,0,1, 4'b1101, 1, 2'd0, 1, 0, 8'd0);
    // early sync on slot 2 restarts the frame
    add(1,1,0, 4'b1101, 0, 2'd1, 1, 0, 8'd0);
    add(1,0,0, 4'b1101, 0, 2'd2, 1, 0, 8'd0);
    add(1,1,1, 4'b1101, 0, 2'd1, 1, 1, 8'd1);
    add(1,0,0, 4'b1101, 0, 2'd2, 1, 0, 8'd1);
    add(1,0,1, 4'b1101, 0, 2'd3, 1, 0, 8'd1);
    add(1,0,0, 4'b1010, 1, 2'd0, 1, 0, 8'd1);
    // missing sync on slot 0 drops lock; HUNT drops unsynced beats silently
    add(1,0,1, 4'b1010, 0, 2'd0, 0, 1, 8'd2);
    add(1,0,1, 4'b1010, 0, 2'd0, 0, 0, 8'd2);
    add(1,1,0, 4'b1010, 0, 2'd1, 1, 0, 8'd2);
    add(1,0,1, 4'b1010, 0, 2'd2, 1, 0, 8'd2);

    do_reset();
    check("reset_state", pack(4'b0000, 0, 2'd0, 0, 0, 8'd0));

    foreach (vecs[i]) begin
      beat(vecs[i].v, vecs[i].fs, vecs[i].d);
      check($sformatf("vec%0d", i),
            pack(vecs[i].outs, vecs[i].wv, vecs[i].slot, vecs[i].lk, vecs[i].se, vecs[i].ec));
    end

    // async reset mid-frame (currently at slot 2) takes effect without a clock edge
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_immediate", pack(4'b0000, 0, 2'd0, 0, 0, 8'd0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    beat(1, 0, 1);
    check("hunt_ignore_1", pack(4'b0000, 0, 2'd0, 0, 0, 8'd0));
    beat(1, 0, 1);
    check("hunt_ignore_2", pack(4'b0000, 0, 2'd0, 0, 0, 8'd0));
    beat(1, 1, 1);
    check("relock", pack(4'b0000, 0, 2'd1, 1, 0, 8'd0));

    // Sync on every beat while at slot 1: each beat is an early-sync error.
    for (int k = 1; k <= 258; k++) begin
      beat(1, 1, 0);
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 258) begin
        check($sformatf("sat_err%0d", k),
              pack(4'b0000, 0, 2'd1, 1, 1, (k >= 255) ? 8'd255 : 8'(k)));
      end
    end
    beat(0, 0, 0);
    check("sat_hold_idle", pack(4'b0000, 0, 2'd1, 1, 0, 8'd255));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
